imm_encoder: RTL

- Narrowing counterpart of the immediate extension unit (IEU).
- Accepts a stream of M-bit constants on a valid/ready handshake.
- Emits each constant as N-bit immediates that the IEU extends back:
  - One word when the value is zero-extendable or sign-extendable.
  - Otherwise a high/low pair, reconstructed as (hi << N) | zero_ext(lo).
- Sits between constant generation and instruction assembly.

---
 rtl/imm_enc_pkg.sv | 21 ++
 rtl/imm_classify.sv | 26 ++
 rtl/imm_encoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg: shared types for the immediate encoder.
// Word kinds, FSM states and value classes.
package imm_enc_pkg;

  localparam logic [1:0] KIND_SINGLE = 2'b00;
  localparam logic [1:0] KIND_HI     = 2'b01;
  localparam logic [1:0] KIND_LO     = 2'b10;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    HI
  } state_e;

  typedef enum logic [1:0] {
    ZEXT,
    SEXT,
    SPLIT
  } cls_e;

endpackage

// File: rtl/imm_classify.sv
// imm_classify: combinational class of an M-bit constant.
// Ports: value_in (M) -> cls (ZEXT, SEXT or SPLIT).
module imm_classify
  import imm_enc_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 32
) (
  input  logic [M-1:0] value_in,
  output cls_e         cls
);

  logic zext;
  logic sext;

  assign zext = (value_in[M-1:N] == '0);
  assign sext = &value_in[M-1:N-1];

  // ZEXT wins so non-negative values always get U=1.
  always_comb begin
    cls = SPLIT;
    if (zext)      cls = ZEXT;
    else if (sext) cls = SEXT;
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: narrows M-bit constants into N-bit immediates
// (SINGLE, or HI then LO). Macro IMM_ENC_STATS_EN adds
// split_cnt/single_cnt. Ports: clk, rst, in_valid/in_ready/
// value_in, out_valid/out_ready/imm_out/U/kind/last.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] value_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] imm_out,
  output logic         U,
  output logic [1:0]   kind,
  output logic         last
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [15:0]  split_cnt,
  output logic [15:0]  single_cnt
`endif
);

  state_e       state_q, state_d;
  logic [N-1:0] imm_q, imm_d;
  logic         u_q, u_d;
  logic [1:0]   kind_q, kind_d;
  logic         last_q, last_d;
  logic [N-1:0] lo_q, lo_d;

  cls_e         cls;
  logic         accept;
  logic [N-1:0] hi_pad;

  imm_classify #(.N(N), .M(M)) u_cls (
    .value_in (value_in),
    .cls      (cls)
  );

  assign in_ready  = (state_q == EMPTY) |
                     ((state_q == ONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q != EMPTY);
  assign imm_out   = imm_q;
  assign U         = u_q;
  assign kind      = kind_q;
  assign last      = last_q;

  always_comb begin
    hi_pad = '0;
    hi_pad[M-N-1:0] = value_in[M-1:N];
  end

  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    u_d     = u_q;
    kind_d  = kind_q;
    last_d  = last_q;
    lo_d    = lo_q;
    unique case (state_q)
      EMPTY, ONE: begin
        if (state_q == ONE && out_ready)
          state_d = EMPTY;
        // A same-cycle accept overrides the drain to EMPTY.
        if (accept) begin
          lo_d  = value_in[N-1:0];
          if (cls == SPLIT) begin
            state_d = HI;
            imm_d   = hi_pad;
            u_d     = 1'b1;
            kind_d  = KIND_HI;
            last_d  = 1'b0;
          end else begin
            state_d = ONE;
            imm_d   = value_in[N-1:0];
            u_d     = (cls == ZEXT);
            kind_d  = KIND_SINGLE;
            last_d  = 1'b1;
          end
        end
      end
      HI: begin
        if (out_ready) begin
          state_d = ONE;
          imm_d   = lo_q;
          u_d     = 1'b1;
          kind_d  = KIND_LO;
          last_d  = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      imm_q   <= '0;
      u_q     <= 1'b0;
      kind_q  <= KIND_SINGLE;
      last_q  <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      u_q     <= u_d;
      kind_q  <= kind_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
    end
  end

`ifdef IMM_ENC_STATS_EN
  logic [15:0] split_cnt_q;
  logic [15:0] single_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      split_cnt_q  <= '0;
      single_cnt_q <= '0;
    end else if (accept) begin
      if (cls == SPLIT) begin
        if (split_cnt_q != 16'hFFFF)
          split_cnt_q <= split_cnt_q + 16'd1;
      end else begin
        if (single_cnt_q != 16'hFFFF)
          single_cnt_q <= single_cnt_q + 16'd1;
      end
    end
  end

  assign split_cnt  = split_cnt_q;
  assign single_cnt = single_cnt_q;
`endif

endmodule
